// File: rtl/video_wr_snoop.sv
// video_wr_snoop: snoops CPU writes that land in a 32KB screen window and
// replays them into a video line buffer through a 4-entry FIFO.
// Each replayed write shows up as a 2-clk pulse on wr followed by a 1-clk gap,
// so the downstream buffer sees exactly one rising edge of |wr per entry.
// Optional feature macro: VIDEO_SNOOP_STATS_EN adds an 8-bit saturating
// drop_count output that counts hits lost to a full FIFO.
//
// Handshake note: there is no valid/ready on the CPU side. A hit is offered
// on the cycle cpu_we is high. It is accepted when the FIFO has room, or when
// the FIFO is full and the output FSM pops an entry at that same edge.
// Otherwise the hit is dropped and overflow is set.
// On the output side, wr != 0 acts as the valid. The consumer is always ready
// and latches the write on the rising edge of |wr.
module video_wr_snoop (
  input  logic        clk,
  input  logic        reset,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_we,
  input  logic [8:0]  vram_base,
  output logic [14:0] addr,
  output logic [15:0] dataIn,
  output logic [1:0]  wr,
  output logic        busy,
  output logic        overflow
`ifdef VIDEO_SNOOP_STATS_EN
  ,
  output logic [7:0]  drop_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  // FSM state, kept as a named signal so checkers can bind to it
  state_t      r_state;
  state_t      w_next;
  logic        r_phase;      // 0 = first ASSERT clk, 1 = second

  // FIFO storage: {word addr[13:0], data[15:0], uds, lds}
  logic [31:0] r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;

  // Output holding registers
  logic [13:0] r_addr;
  logic [15:0] r_data;
  logic [1:0]  r_be;
  logic        r_overflow;

  logic        w_hit;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [31:0] w_entry;
  logic [31:0] w_head;

  // cpu_addr holds byte address bits [23:1]; byte bits [23:15] sit at [22:14]
  assign w_hit   = cpu_we && (cpu_addr[22:14] == vram_base) && (!cpu_uds_n || !cpu_lds_n);
  assign w_entry = {cpu_addr[13:0], cpu_data, ~cpu_uds_n, ~cpu_lds_n};
  assign w_head  = r_mem[r_rd_ptr];

  // The FSM pops only entries already registered, so push/pop never collide at count 0.
  // GAP pops directly when work is waiting, giving one entry every 3 clk.
  assign w_pop  = ((r_state == S_IDLE) || (r_state == S_GAP)) && (r_count != 3'd0);
  assign w_push = w_hit && ((r_count != 3'd4) || w_pop);
  assign w_drop = w_hit && !w_push;

  // FSM state register and ASSERT phase tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_next;
      r_phase <= (r_state == S_ASSERT) ? ~r_phase : 1'b0;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_next = S_ASSERT;
      S_ASSERT: if (r_phase) w_next = S_GAP;
      S_GAP:    w_next = w_pop ? S_ASSERT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs: enables only while asserting, busy covers queue and FSM
  always_comb begin
    wr   = 2'b00;
    busy = (r_count != 3'd0) || (r_state != S_IDLE);
    if (r_state == S_ASSERT) wr = r_be;
  end

  // FIFO storage write (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output registers load on pop and hold their value otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= 14'd0;
      r_data <= 16'd0;
      r_be   <= 2'b00;
    end else if (w_pop) begin
      r_addr <= w_head[31:18];
      r_data <= w_head[17:2];
      r_be   <= w_head[1:0];
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign addr     = {1'b0, r_addr};
  assign dataIn   = r_data;
  assign overflow = r_overflow;

`ifdef VIDEO_SNOOP_STATS_EN
  logic [7:0] r_drop_count;

  // Saturating count of dropped hits
  always_ff @(posedge clk) begin
    if (reset)                               r_drop_count <= 8'd0;
    else if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
  end

  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_video_wr_snoop.sv
// tb_video_wr_snoop: directed bench for video_wr_snoop.
// Inputs are driven and outputs are sampled 1 time unit after the rising edge.
// A monitor process matches every new write (rising |wr) against exp_q.
// It also checks the 2-clk hold time and the entry-to-entry spacing.
module tb_video_wr_snoop;

  localparam int W = 33;  // {addr[14:0], dataIn[15:0], wr[1:0]}

  logic        clk;
  logic        reset;
  logic [22:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic        cpu_we;
  logic [8:0]  vram_base;
  logic [14:0] addr;
  logic [15:0] dataIn;
  logic [1:0]  wr;
  logic        busy;
  logic        overflow;
`ifdef VIDEO_SNOOP_STATS_EN
  logic [7:0]  drop_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           rise_q[$];
  logic         mon_en = 1'b1;
  logic [1:0]   mon_prev = 2'b00;
  logic [1:0]   mon_held = 2'b00;
  int           mon_run = 0;
  logic         mon_run_rst = 1'b0;

  video_wr_snoop dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_uds_n (cpu_uds_n),
    .cpu_lds_n (cpu_lds_n),
    .cpu_we    (cpu_we),
    .vram_base (vram_base),
    .addr      (addr),
    .dataIn    (dataIn),
    .wr        (wr),
    .busy      (busy),
    .overflow  (overflow)
`ifdef VIDEO_SNOOP_STATS_EN
    ,
    .drop_count(drop_count)
`endif
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected entry as seen on the output: word address is byte bits [14:1]
  function automatic logic [W-1:0] ent(input logic [23:0] ba, input logic [15:0] d,
                                       input logic [1:0] be);
    return {1'b0, ba[14:1], d, be};
  endfunction

  // One-clk CPU write; be[1] = upper strobe, be[0] = lower strobe
  task automatic hit(input logic [23:0] ba, input logic [15:0] d, input logic [1:0] be);
    cpu_addr  = ba[23:1];
    cpu_data  = d;
    cpu_uds_n = ~be[1];
    cpu_lds_n = ~be[0];
    cpu_we    = 1'b1;
    tick();
    cpu_we    = 1'b0;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", W'(busy), W'(1'b0));
    repeat (2) tick();
  endtask

  // Output monitor: scoreboard match on each new write, hold-time and stability checks
  always begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      if (wr != 2'b00 && mon_prev == 2'b00) begin
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_wr", {addr, dataIn, wr}, W'(0));
        else                   chk("wr_entry", {addr, dataIn, wr}, exp_q.pop_front());
        mon_run     = 1;
        mon_run_rst = reset;
        mon_held    = wr;
      end else if (wr != 2'b00) begin
        mon_run++;
        if (reset) mon_run_rst = 1'b1;
        chk("wr_stable", W'(wr), W'(mon_held));
      end else if (mon_prev != 2'b00 && !mon_run_rst) begin
        chk("assert_len", W'(mon_run), W'(2));
      end
    end
    mon_prev = wr;
  end

  initial begin
    reset     = 1'b1;
    cpu_addr  = '0;
    cpu_data  = '0;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    cpu_we    = 1'b0;
    vram_base = 9'h07F;
    repeat (3) tick();

    // Reset state
    chk("rst_wr", W'(wr), W'(0));
    chk("rst_addr", W'(addr), W'(0));
    chk("rst_dataIn", W'(dataIn), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_overflow", W'(overflow), W'(0));
`ifdef VIDEO_SNOOP_STATS_EN
    chk("rst_drop_count", W'(drop_count), W'(0));
`endif
    reset = 1'b0;
    tick();

    // Single full-word hit: latency E0 -> wr after E1, held 2 clk, gap after E3
    exp_q.push_back(ent(24'h3FA700, 16'hA5C3, 2'b11));
    hit(24'h3FA700, 16'hA5C3, 2'b11);                       // after E0
    chk("lat_e0_wr", W'(wr), W'(0));
    chk("lat_e0_busy", W'(busy), W'(1));
    tick();                                                 // after E1
    chk("lat_e1_wr", W'(wr), W'(2'b11));
    chk("lat_e1_addr", W'(addr), W'(15'h1380));
    chk("lat_e1_data", W'(dataIn), W'(16'hA5C3));
    tick();                                                 // after E2
    chk("lat_e2_wr", W'(wr), W'(2'b11));
    tick();                                                 // after E3
    chk("lat_e3_wr", W'(wr), W'(0));
    chk("lat_e3_addr_hold", W'(addr), W'(15'h1380));
    chk("lat_e3_data_hold", W'(dataIn), W'(16'hA5C3));
    tick();                                                 // after E4
    chk("lat_e4_busy", W'(busy), W'(0));
    wait_idle();

    // Byte strobes
    exp_q.push_back(ent(24'h3F8002, 16'h1234, 2'b10));
    hit(24'h3F8002, 16'h1234, 2'b10);
    wait_idle();
    exp_q.push_back(ent(24'h3FFFFE, 16'hBEEF, 2'b01));
    hit(24'h3FFFFE, 16'hBEEF, 2'b01);
    wait_idle();
    hit(24'h3FA000, 16'h5555, 2'b00);                       // no strobe: not a hit
    chk("no_strobe_busy", W'(busy), W'(0));
    tick();
    chk("no_strobe_busy2", W'(busy), W'(0));

    // Outside the window
    hit(24'h3F0000, 16'h7777, 2'b11);
    chk("miss_busy", W'(busy), W'(0));
    repeat (4) tick();
    chk("miss_wr", W'(wr), W'(0));

    // Different window base
    vram_base = 9'h000;
    exp_q.push_back(ent(24'h000100, 16'hC0DE, 2'b11));
    hit(24'h000100, 16'hC0DE, 2'b11);
    wait_idle();
    vram_base = 9'h07F;

    // Burst of 8 consecutive hits. Pops land at E1, E4, E7, ...
    // At E6 the FIFO holds 4 entries and the FSM is heading into GAP, so hit 7 is dropped.
    // At E7 the FIFO is full but GAP pops, so hit 8 is accepted.
    rise_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (i != 6) exp_q.push_back(ent(24'h3F8000 + 24'(2 * i), 16'hB000 + 16'(i), 2'b11));
    end
    for (int i = 0; i < 8; i++) begin
      hit(24'h3F8000 + 24'(2 * i), 16'hB000 + 16'(i), 2'b11);
      if (i == 5) chk("burst_no_ovf_yet", W'(overflow), W'(0));
      if (i == 6) chk("burst_ovf_set", W'(overflow), W'(1));
    end
`ifdef VIDEO_SNOOP_STATS_EN
    chk("burst_drop_count", W'(drop_count), W'(1));
`endif
    wait_idle();
    chk("burst_ovf_sticky", W'(overflow), W'(1));
    chk("burst_rises", W'(rise_q.size()), W'(7));
    for (int i = 0; i + 1 < rise_q.size(); i++)
      chk("throughput", W'(rise_q[i+1] - rise_q[i]), W'(3));

    // Reset during ASSERT with 3 queued.
    // After E4 the FSM asserts hit 2 and hits 3-5 are queued.
    exp_q.push_back(ent(24'h3FA100, 16'hD001, 2'b11));
    exp_q.push_back(ent(24'h3FA102, 16'hD002, 2'b11));
    for (int i = 0; i < 5; i++) hit(24'h3FA100 + 24'(2 * i), 16'hD001 + 16'(i), 2'b11);
    chk("pre_rst_wr", W'(wr), W'(2'b11));
    reset = 1'b1;
    hit(24'h3FA200, 16'hEEEE, 2'b11);                       // hit coincident with reset
    chk("mid_rst_wr", W'(wr), W'(0));
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_ovf", W'(overflow), W'(0));
    chk("mid_rst_addr", W'(addr), W'(0));
    chk("mid_rst_data", W'(dataIn), W'(0));
    reset = 1'b0;
    repeat (10) tick();
    chk("post_rst_busy", W'(busy), W'(0));
    chk("post_rst_wr", W'(wr), W'(0));

`ifdef VIDEO_SNOOP_STATS_EN
    // Saturating drop counter: continuous hits drop 2 of every 3
    chk("stats_start", W'(drop_count), W'(0));
    mon_en = 1'b0;
    for (int i = 0; i < 600; i++) hit(24'h3FA400, 16'h0F0F, 2'b11);
    chk("stats_sat", W'(drop_count), W'(255));
    for (int i = 0; i < 10; i++) hit(24'h3FA400, 16'h0F0F, 2'b11);
    chk("stats_hold", W'(drop_count), W'(255));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stats_rst", W'(drop_count), W'(0));
    repeat (3) tick();
    mon_en = 1'b1;
`endif

    chk("exp_q_empty", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
